ahb_lite_sram_slave: RTL

//  AHB-Lite memory slave that sits directly downstream of the AHB interface bundle.
//  It consumes the address/control and write data driven by the master and returns HRDATA/HREADYOUT/HRESP.
//  It provides word-array storage, programmable wait states, size/alignment/range checks and a 2-cycle ERROR response.
//  It is the default responder in single-slave benches (HREADY = HREADYOUT).

---
 rtl/ahb_lite_sram_slave.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite word-array memory slave with programmable wait states and a
// two-cycle ERROR response for oversize, misaligned or out-of-range transfers.
module ahb_lite_sram_slave #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [2:0]        HBURST,
   input  logic [3:0]        HPROT,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic [1:0]        HRESP,
   output logic [DATA_W-1:0] HRDATA
);

   localparam int LANES     = DATA_W / 8;
   localparam int LANE_BITS = $clog2(LANES);
   localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam longint unsigned MEM_BYTES = longint'(MEM_DEPTH) * longint'(LANES);
   localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

   state_t               state_reg, state_next;
   logic [3:0]           cnt_reg, cnt_next;
   logic [ADDR_W-1:0]    addr_reg;
   logic [2:0]           size_reg;
   logic                 write_reg;
   logic                 capture, ready, rd_phase, wr_commit;
   logic                 accept, acc_err;
   logic [ADDR_W-1:0]    align_mask;
   logic [IDX_W-1:0]     word_idx;
   logic [LANE_BITS-1:0] lane_off;
   logic [LANES-1:0]     be;
   logic [DATA_W-1:0]    mem [MEM_DEPTH];
   logic                 unused_ok;

   assign accept     = HSEL & HREADY & HTRANS[1];
   assign align_mask = ADDR_W'((64'd1 << HSIZE) - 64'd1);
   assign acc_err    = (HSIZE > 3'(LANE_BITS)) || ((HADDR & align_mask) != '0) ||
                       (64'(HADDR) >= MEM_BYTES);

   assign word_idx = addr_reg[LANE_BITS +: IDX_W];
   assign lane_off = addr_reg[LANE_BITS-1:0];

   // Little-endian lane enables covering 2**size_reg bytes from the low address bits.
   for (genvar gi = 0; gi < LANES; gi++) begin : g_be
      assign be[gi] = (gi >= int'(lane_off)) && (gi < int'(lane_off) + (1 << size_reg));
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         addr_reg  <= '0;
         size_reg  <= '0;
         write_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (capture) begin
            addr_reg  <= HADDR;
            size_reg  <= HSIZE;
            write_reg <= HWRITE;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      capture    = 1'b0;
      ready      = 1'b1;
      HRESP      = 2'b00;
      rd_phase   = 1'b0;
      wr_commit  = 1'b0;
      case (state_reg)
         IDLE: state_next = IDLE;
         DATA: begin
            ready = (cnt_reg == 4'd0);
            if (cnt_reg != 4'd0) begin
               cnt_next = cnt_reg - 4'd1;
            end else begin
               rd_phase   = !write_reg;
               wr_commit  = write_reg && !HRESET;
               state_next = IDLE;
            end
         end
         ERR1: begin
            ready      = 1'b0;
            HRESP      = 2'b01;
            state_next = ERR2;
         end
         ERR2: begin
            HRESP      = 2'b01;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // A new address phase is only taken while this slave is presenting ready.
      if (ready && accept) begin
         capture    = 1'b1;
         state_next = acc_err ? ERR1 : DATA;
         cnt_next   = WAIT_CNT;
      end
   end

   assign HREADYOUT = ready;
   assign HRDATA    = rd_phase ? mem[word_idx] : '0;

   always_ff @(posedge HCLK) begin
      if (wr_commit) begin
         for (int b = 0; b < LANES; b++) begin
            if (be[b]) mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
         end
      end
   end

   assign unused_ok = ^{HBURST, HPROT, HTRANS[0], addr_reg};

endmodule
